// File: rtl/ct_pkg.sv
// Shared types and helpers for the circuit-tree (ct_*) interconnect nodes.
package ct_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } ct_merge_state_e;

    // Index width that never collapses to zero bits, so a single-input node still has a select.
    function automatic int ct_clog2_min1(input int n);
        int w;
        w = 0;
        for (int k = 0; (1 << k) < n; k++) begin
            w = k + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ct_merge_rr_pick.sv
// Combinational priority picker: first set request bit searching upward from start, wrapping at NI.
module ct_rr_pick
    import ct_pkg::*;
#(
    parameter int NI = 2,
    parameter int WS = 1
) (
    input  logic [NI-1:0] req,
    input  logic [WS-1:0] start,
    output logic [WS-1:0] winner,
    output logic          any
);

    // Walk offsets from the far end down so the nearest request after start is written last.
    always_comb begin
        int s;
        int idx;
        winner = '0;
        any    = |req;
        s      = int'(start);
        if (s >= NI) begin
            s = 0;
        end
        for (int off = NI - 1; off >= 0; off--) begin
            idx = s + off;
            if (idx >= NI) begin
                idx = idx - NI;
            end
            if (req[idx]) begin
                winner = WS'(idx);
            end
        end
    end

endmodule

// File: rtl/ct_merge.sv
// Packet-aware N-to-1 merge node; holds the grant from first beat to eop.
// Define CT_MERGE_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module ct_merge
    import ct_pkg::*;
#(
    parameter int  NI = 2,
    parameter int  WO = 1,
    parameter int  WF = 1,
    localparam int WS = ct_clog2_min1(NI)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NI*WO-1:0] i_data,
    input  logic [NI*WF-1:0] i_flow,
    input  logic [NI-1:0]  i_eop,
    input  logic [NI-1:0]  i_valid,
    output logic [NI-1:0]  o_ready,
    output logic [WO-1:0]  o_data,
    output logic [WF-1:0]  o_flow,
    output logic           o_eop,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [WS-1:0]  o_sel
);

    ct_merge_state_e state;
    logic [WS-1:0]   grant;
    logic [WS-1:0]   start;
    logic [WS-1:0]   pick;
    logic            any_req;
    logic [WS-1:0]   winner;
    logic            sel_valid;
    logic            sel_eop;
    logic            transfer;

`ifdef CT_MERGE_RR_EN
    logic [WS-1:0] rr_ptr;

    function automatic logic [WS-1:0] wrap_inc(input logic [WS-1:0] x);
        return (int'(x) >= NI - 1) ? '0 : x + 1'b1;
    endfunction

    assign start = rr_ptr;
`else
    assign start = '0;
`endif

    ct_rr_pick #(
        .NI(NI),
        .WS(WS)
    ) u_pick (
        .req   (i_valid),
        .start (start),
        .winner(pick),
        .any   (any_req)
    );

    // With no request in IDLE the select rests on the grant register.
    always_comb begin
        winner    = grant;
        sel_valid = 1'b0;
        if (state == LOCKED) begin
            winner    = grant;
            sel_valid = i_valid[grant];
        end else if (any_req) begin
            winner    = pick;
            sel_valid = 1'b1;
        end
    end

    always_comb begin
        int w;
        w       = int'(winner);
        o_data  = i_data[w*WO +: WO];
        o_flow  = i_flow[w*WF +: WF];
        sel_eop = i_eop[w];
        o_ready = '0;
        for (int k = 0; k < NI; k++) begin
            o_ready[k] = !reset && (w == k) && i_ready;
        end
        o_valid = sel_valid && !reset;
        o_sel   = reset ? '0 : winner;
    end

    assign o_eop    = sel_eop;
    assign transfer = sel_valid && i_ready;

    // A stalled first beat also locks, so the presented data cannot be re-arbitrated away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
`ifdef CT_MERGE_RR_EN
            rr_ptr <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        if (transfer && sel_eop) begin
`ifdef CT_MERGE_RR_EN
                            rr_ptr <= wrap_inc(winner);
`endif
                        end else begin
                            state <= LOCKED;
                            grant <= winner;
                        end
                    end
                end
                LOCKED: begin
                    if (transfer && sel_eop) begin
                        state <= IDLE;
`ifdef CT_MERGE_RR_EN
                        rr_ptr <= wrap_inc(grant);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (reset) $onehot0(o_ready));

endmodule

// File: tb/tb_ct_merge.sv
// Self-checking bench for ct_merge (NI=4); expectations follow CT_MERGE_RR_EN when defined.
module tb_ct_merge;

    localparam int NI = 4;
    localparam int WO = 8;
    localparam int WF = 2;
    localparam int WS = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [NI*WO-1:0] i_data;
    logic [NI*WF-1:0] i_flow;
    logic [NI-1:0]    i_eop;
    logic [NI-1:0]    i_valid;
    logic [NI-1:0]    o_ready;
    logic [WO-1:0]    o_data;
    logic [WF-1:0]    o_flow;
    logic             o_eop;
    logic             o_valid;
    logic             i_ready;
    logic [WS-1:0]    o_sel;

    ct_merge #(
        .NI(NI),
        .WO(WO),
        .WF(WF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .i_data (i_data),
        .i_flow (i_flow),
        .i_eop  (i_eop),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_data (o_data),
        .o_flow (o_flow),
        .o_eop  (o_eop),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_sel  (o_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] v;
        logic [3:0] e;
        logic       r;
        logic [3:0] seed;
        int         sel_fp;
        int         sel_rr;
        logic       ov;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0] sel;
        logic       ov;
        logic [3:0] ordy;
        logic [7:0] data;
        logic [1:0] flow;
        logic       eop;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [7:0] data_of(input int k, input logic [3:0] seed);
        return {k[3:0], seed};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] e, input logic r, input logic [3:0] seed);
        i_valid = v;
        i_eop   = e;
        i_ready = r;
        for (int k = 0; k < NI; k++) begin
            i_data[k*WO +: WO] = data_of(k, seed);
            i_flow[k*WF +: WF] = k[1:0];
        end
    endtask

    task automatic check_scoreboard();
        exp_t x;
        if (sb.size() == 0) begin
            check_output("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        x = sb.pop_front();
        check_output({x.name, "/sel"},   32'(o_sel),   32'(x.sel));
        check_output({x.name, "/valid"}, 32'(o_valid), 32'(x.ov));
        check_output({x.name, "/ready"}, 32'(o_ready), 32'(x.ordy));
        check_output({x.name, "/data"},  32'(o_data),  32'(x.data));
        check_output({x.name, "/flow"},  32'(o_flow),  32'(x.flow));
        check_output({x.name, "/eop"},   32'(o_eop),   32'(x.eop));
    endtask

    task automatic apply_stimulus(input vec_t t);
        exp_t x;
        int   sel;
        @(negedge clk);
        drive(t.v, t.e, t.r, t.seed);
`ifdef CT_MERGE_RR_EN
        sel = t.sel_rr;
`else
        sel = t.sel_fp;
`endif
        x.name = t.name;
        x.sel  = sel[1:0];
        x.ov   = t.ov;
        x.ordy = t.r ? (4'b0001 << sel) : 4'b0000;
        x.data = data_of(sel, t.seed);
        x.flow = sel[1:0];
        x.eop  = t.e[sel];
        sb.push_back(x);
        #1;
        check_scoreboard();
    endtask

    initial begin
        reset = 1'b1;
        drive(4'b1111, 4'b1111, 1'b1, 4'h0);
        #1;
        check_output("reset/valid", 32'(o_valid), 32'd0);
        check_output("reset/ready", 32'(o_ready), 32'd0);
        check_output("reset/sel",   32'(o_sel),   32'd0);
        @(negedge clk);
        reset = 1'b0;

        //              name        v        e        r     seed  fp rr ov
        vecs.push_back('{"fair0",   4'b1111, 4'b1111, 1'b1, 4'h1, 0, 0, 1'b1});
        vecs.push_back('{"fair1",   4'b1111, 4'b1111, 1'b1, 4'h2, 0, 1, 1'b1});
        vecs.push_back('{"fair2",   4'b1111, 4'b1111, 1'b1, 4'h3, 0, 2, 1'b1});
        vecs.push_back('{"fair3",   4'b1111, 4'b1111, 1'b1, 4'h4, 0, 3, 1'b1});
        vecs.push_back('{"fair4",   4'b1111, 4'b1111, 1'b1, 4'h5, 0, 0, 1'b1});
        vecs.push_back('{"single0", 4'b0001, 4'b1111, 1'b1, 4'h6, 0, 0, 1'b1});
        vecs.push_back('{"single1", 4'b0001, 4'b1111, 1'b1, 4'h7, 0, 0, 1'b1});
        vecs.push_back('{"single2", 4'b0001, 4'b1111, 1'b1, 4'h8, 0, 0, 1'b1});
        vecs.push_back('{"idle",    4'b0000, 4'b0000, 1'b1, 4'h9, 0, 0, 1'b0});
        vecs.push_back('{"fixed0",  4'b1001, 4'b1111, 1'b1, 4'hA, 0, 3, 1'b1});
        vecs.push_back('{"fixed1",  4'b1001, 4'b1111, 1'b1, 4'hB, 0, 0, 1'b1});
        vecs.push_back('{"fixed2",  4'b1001, 4'b1111, 1'b1, 4'hC, 0, 3, 1'b1});
        vecs.push_back('{"lock_a",  4'b0010, 4'b0001, 1'b1, 4'h1, 1, 1, 1'b1});
        vecs.push_back('{"lock_b",  4'b0011, 4'b0001, 1'b1, 4'h2, 1, 1, 1'b1});
        vecs.push_back('{"lock_drop", 4'b0001, 4'b0001, 1'b1, 4'h3, 1, 1, 1'b0});
        vecs.push_back('{"lock_eop", 4'b0011, 4'b0011, 1'b1, 4'h4, 1, 1, 1'b1});
        vecs.push_back('{"lock_next", 4'b0011, 4'b0011, 1'b1, 4'h5, 0, 0, 1'b1});
        vecs.push_back('{"stall0",  4'b0100, 4'b0100, 1'b0, 4'hD, 2, 2, 1'b1});
        vecs.push_back('{"stall1",  4'b0101, 4'b0101, 1'b0, 4'hD, 2, 2, 1'b1});
        vecs.push_back('{"stall2",  4'b0101, 4'b0101, 1'b0, 4'hD, 2, 2, 1'b1});
        vecs.push_back('{"stall3",  4'b0101, 4'b0101, 1'b0, 4'hD, 2, 2, 1'b1});
        vecs.push_back('{"stall_go", 4'b0101, 4'b0101, 1'b1, 4'hD, 2, 2, 1'b1});
        vecs.push_back('{"after_stall", 4'b0101, 4'b0101, 1'b1, 4'hE, 0, 0, 1'b1});
        vecs.push_back('{"rst_lock", 4'b0010, 4'b0000, 1'b1, 4'h6, 1, 1, 1'b1});
        vecs.push_back('{"rst_hold", 4'b0011, 4'b0000, 1'b1, 4'h7, 1, 1, 1'b1});

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
        end

        // Reset arrives asynchronously while input 1 holds the lock mid-packet.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_output("midrst/valid", 32'(o_valid), 32'd0);
        check_output("midrst/ready", 32'(o_ready), 32'd0);
        check_output("midrst/sel",   32'(o_sel),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);

        apply_stimulus('{"post_rst0", 4'b0011, 4'b0011, 1'b1, 4'h8, 0, 0, 1'b1});
        apply_stimulus('{"post_rst1", 4'b0010, 4'b0010, 1'b1, 4'h9, 1, 1, 1'b1});

        check_output("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ct_merge.md
# ct_merge

Packet-aware N-to-1 merge node for the circuit-tree (ct_*) interconnect; the counterpart of the split node. It arbitrates NI valid/ready input streams onto one output link and holds the grant from first beat to end-of-packet (eop), so packets from different sources never interleave. Arbitration is zero-latency: a grant is issued in the same cycle the request is seen. Data, flow_id and eop pass through combinationally from the granted input.

## Interface
- NI, 2: number of inputs (≥1)
- WO, 1: data width
- WF, 1: flow_id width
- WS, derived: max(1, $clog2(NI)); grant index width (localparam)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- i_data  in  NI*WO  input data, input k at [k*WO +: WO]
- i_flow  in  NI*WF  input flow_id, input k at [k*WF +: WF]
- i_eop  in  NI  last beat of packet, per input
- i_valid  in  NI  per-input valid
- o_ready  out  NI  per-input ready
- o_data  out  WO  granted input's data
- o_flow  out  WF  granted input's flow_id
- o_eop  out  1  granted input's eop
- o_valid  out  1  output valid
- i_ready  in  1  downstream ready
- o_sel  out  WS  current grant index

## Operation
- States: IDLE, LOCKED. Registers: state, grant (WS), rr_ptr (WS).
- IDLE: winner = first valid input searching upward from rr_ptr with wrap (k = rr_ptr, rr_ptr+1, …, NI-1, 0, …). No valid input → o_valid=0, o_sel=grant register value.
- LOCKED: winner = grant register; other inputs ignored regardless of valid.
- Outputs: o_valid = i_valid[winner] (IDLE: 1 if any valid); o_data/o_flow/o_eop = input winner; o_ready[winner] = i_ready; every other o_ready = 0. o_sel = winner.
- Transfer = o_valid & i_ready.
- Transitions (registered at posedge clk):
  - IDLE, transfer with o_eop=1 → stay IDLE; rr_ptr ← winner+1 (wrap at NI).
  - IDLE, transfer with o_eop=0 → LOCKED; grant ← winner.
  - IDLE, o_valid & !i_ready → LOCKED; grant ← winner. This keeps presented data stable until accepted.
  - LOCKED, transfer with o_eop=1 → IDLE; rr_ptr ← grant+1 (wrap).
  - LOCKED, anything else → stay LOCKED. This includes the granted input dropping i_valid mid-packet; output then shows o_valid=0.
- Wrap: increment modulo NI; for NI not a power of two, NI-1 wraps to 0.
- NI=1: input 0 always granted; FSM still tracks eop. o_sel=0.

## Timing
- Combinational paths: i_valid/i_data/i_flow/i_eop → outputs, and i_ready → o_ready. No registers on the data path; zero latency.
- Grant change takes effect the cycle after a completing (eop) transfer. Back-to-back packets from different inputs run at one beat per cycle.
- Reset (async): state=IDLE, grant=0, rr_ptr=0. While reset is high: o_valid=0, all o_ready=0, o_sel=0.
- Reset mid-packet: lock is discarded; the next packet is arbitrated from input 0 after reset.
- Simultaneous requests in IDLE: exactly one grant, per the search order above.

## Configuration
- CT_MERGE_RR_EN defined: round-robin arbitration as described, with rr_ptr updated on every completing transfer.
- CT_MERGE_RR_EN undefined: fixed priority. The lowest valid index wins in IDLE. rr_ptr is not instantiated; the search always starts at 0. Lock behaviour is unchanged.

## Structure
- The shared package ct_pkg holds the ct_merge_state_e enum (IDLE, LOCKED) and the ct_clog2_min1 width helper function.
- Sub-module ct_rr_pick: combinational priority picker (NI request bits, WS-bit start pointer → winner index, any-valid flag). It is also reusable by future ct arbiters.
- Simulation assertion: when reset is low, o_ready must have at most one bit set.

## Test plan
- Single input streaming: i_valid=01, eop on every beat, i_ready=1 → o_sel=0, one transfer per cycle, o_ready=01.
- Round-robin fairness (CT_MERGE_RR_EN, NI=4): all inputs valid with 1-beat packets → grant order 0,1,2,3,0.
- Packet lock: input 1 sends a 3-beat packet (eop on beat 3) while input 0 is valid throughout → o_sel=1 for 3 beats and o_ready[0]=0, then o_sel=0.
- Stall hold: in IDLE, input 2 valid with i_ready=0 for 4 cycles while input 0 becomes valid → o_sel stays 2 and o_data is stable; the transfer completes when i_ready=1.
- Fixed priority (macro undefined): inputs 0 and 3 continuously valid with 1-beat packets → input 0 always granted.
- Async reset while LOCKED mid-packet → o_valid=0 immediately; after release, state=IDLE and input 0 has priority.
